// File: rtl/mlp_seq_ctrl.sv
// mlp_seq_ctrl: loads MLP weights/biases from a byte stream, then sequences inference
// requests through a slow combinational datapath with a fixed settle window.
`default_nettype none

module mlp_seq_ctrl #(
   parameter int IN_W       = 32,
   parameter int W_W        = 264,
   parameter int B_W        = 72,
   parameter int OUT_W      = 2,
   parameter int SETTLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [7:0]       cfg_data,
   input  logic             cfg_clear,
   output logic             param_loaded,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_class,
   output logic             busy,
   output logic [IN_W-1:0]  mlp_inp,
   output logic [W_W-1:0]   mlp_weights,
   output logic [B_W-1:0]   mlp_biases,
   input  logic [OUT_W-1:0] mlp_out
);

   localparam int P_W    = W_W + B_W;
   localparam int NBYTES = P_W / 8;
   localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int SC_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      IDLE  = 2'd1,
      EVAL  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state;
   logic [BC_W-1:0] bcnt;
   logic [SC_W-1:0] scnt;
   logic [P_W-1:0]  param_img;

   // Handshake flags depend on the state register only, never on inputs.
   assign cfg_ready   = (state == EMPTY);
   assign in_ready    = (state == IDLE);
   assign out_valid   = (state == DONE);
   assign busy        = (state == EVAL) || (state == DONE);
   assign mlp_weights = param_img[W_W-1:0];
   assign mlp_biases  = param_img[P_W-1:W_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= EMPTY;
         bcnt         <= '0;
         scnt         <= '0;
         param_img    <= '0;
         mlp_inp      <= '0;
         out_class    <= '0;
         param_loaded <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (cfg_valid) begin
                  param_img[{bcnt, 3'b000} +: 8] <= cfg_data;
                  if (bcnt == BC_W'(NBYTES - 1)) begin
                     bcnt         <= '0;
                     param_loaded <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
               end
            end
            IDLE: begin
               // A clear request takes priority over a coincident inference request.
               if (cfg_clear) begin
                  param_loaded <= 1'b0;
                  bcnt         <= '0;
                  state        <= EMPTY;
               end else if (in_valid) begin
                  mlp_inp <= in_data;
                  scnt    <= SC_W'(SETTLE_CYC - 1);
                  state   <= EVAL;
               end
            end
            EVAL: begin
               if (scnt == '0) begin
                  out_class <= mlp_out;
                  state     <= DONE;
               end else begin
                  scnt <= scnt - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mlp_seq_ctrl.sv
// Directed bench for mlp_seq_ctrl: one instance with a 4-cycle settle window, one with 1.
`default_nettype none

module tb_mlp_seq_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cfg_valid;
   logic [7:0]   cfg_data;
   logic         cfg_clear, cfg_clear_1;
   logic         in_valid, in_valid_1;
   logic [31:0]  in_data, in_data_1;
   logic         out_ready, out_ready_1;
   logic [1:0]   mlp_out, mlp_out_1;

   logic         cfg_ready, param_loaded, in_ready, out_valid, busy;
   logic [1:0]   out_class;
   logic [31:0]  mlp_inp;
   logic [263:0] mlp_weights;
   logic [71:0]  mlp_biases;

   logic         cfg_ready_1, param_loaded_1, in_ready_1, out_valid_1, busy_1;
   logic [1:0]   out_class_1;
   logic [31:0]  mlp_inp_1;
   logic [263:0] mlp_weights_1;
   logic [71:0]  mlp_biases_1;

   int           total = 0;
   int           bad   = 0;
   logic [263:0] exp_w;
   logic [71:0]  exp_b;

   always #5 clk = ~clk;

   mlp_seq_ctrl #(.IN_W(32), .W_W(264), .B_W(72), .OUT_W(2), .SETTLE_CYC(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
      .cfg_clear(cfg_clear), .param_loaded(param_loaded),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
      .busy(busy), .mlp_inp(mlp_inp), .mlp_weights(mlp_weights),
      .mlp_biases(mlp_biases), .mlp_out(mlp_out)
   );

   mlp_seq_ctrl #(.IN_W(32), .W_W(264), .B_W(72), .OUT_W(2), .SETTLE_CYC(1)) u_dut_1 (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_1), .cfg_data(cfg_data),
      .cfg_clear(cfg_clear_1), .param_loaded(param_loaded_1),
      .in_valid(in_valid_1), .in_ready(in_ready_1), .in_data(in_data_1),
      .out_valid(out_valid_1), .out_ready(out_ready_1), .out_class(out_class_1),
      .busy(busy_1), .mlp_inp(mlp_inp_1), .mlp_weights(mlp_weights_1),
      .mlp_biases(mlp_biases_1), .mlp_out(mlp_out_1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Streams a full parameter image (byte k = k ^ seed) and records the expected image.
   task automatic load_all(input logic [7:0] seed, output int rdy_cnt);
      rdy_cnt   = 0;
      cfg_valid = 1'b1;
      for (int k = 0; k < 42; k++) begin
         cfg_data = 8'(k) ^ seed;
         if (k < 33) exp_w[8*k +: 8] = cfg_data;
         else        exp_b[8*(k-33) +: 8] = cfg_data;
         if (cfg_ready) rdy_cnt++;
         tick();
      end
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
      total++; if ({in_ready, param_loaded, out_valid, busy} !== 4'b0000) begin bad++;
         $display("FAIL reset_flags got=%b exp=0000", {in_ready, param_loaded, out_valid, busy}); end
      total++; if (mlp_inp !== 32'h0 || out_class !== 2'b00) begin bad++;
         $display("FAIL reset_inp_class got=%h/%b exp=0/00", mlp_inp, out_class); end
      total++; if (mlp_weights !== 264'h0 || mlp_biases !== 72'h0) begin bad++;
         $display("FAIL reset_params got nonzero weights/biases"); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load;
      int cnt = 0;
      cfg_valid = 1'b1;
      for (int k = 0; k < 42; k++) begin
         cfg_data = 8'(k);
         if (k < 33) exp_w[8*k +: 8] = 8'(k);
         else        exp_b[8*(k-33) +: 8] = 8'(k);
         if (cfg_ready) cnt++;
         if (k == 41) begin
            total++; if (param_loaded !== 1'b0) begin bad++; $display("FAIL load_early got=%b exp=0", param_loaded); end
         end
         tick();
      end
      cfg_valid = 1'b0;
      total++; if (cnt != 42) begin bad++; $display("FAIL load_ready_cycles got=%0d exp=42", cnt); end
      total++; if ({param_loaded, in_ready, cfg_ready} !== 3'b110) begin bad++;
         $display("FAIL load_done_flags got=%b exp=110", {param_loaded, in_ready, cfg_ready}); end
      total++; if (mlp_weights[7:0] !== 8'h00 || mlp_biases[7:0] !== 8'h21 || mlp_biases[71:64] !== 8'h29) begin bad++;
         $display("FAIL load_bytes got w0=%h b0=%h b8=%h exp=00/21/29", mlp_weights[7:0], mlp_biases[7:0], mlp_biases[71:64]); end
      total++; if (mlp_weights !== exp_w || mlp_biases !== exp_b) begin bad++;
         $display("FAIL load_image got w=%h b=%h", mlp_weights, mlp_biases); end
      total++; if (param_loaded_1 !== 1'b1) begin bad++; $display("FAIL load_dut1 got=%b exp=1", param_loaded_1); end
   endtask

   task automatic test_cfg_ignored;
      cfg_valid = 1'b1;
      cfg_data  = 8'hFF;
      tick();
      tick();
      cfg_valid = 1'b0;
      total++; if (mlp_weights !== exp_w || mlp_biases !== exp_b || cfg_ready !== 1'b0) begin bad++;
         $display("FAIL cfg_ignored got cfg_ready=%b w0=%h", cfg_ready, mlp_weights[7:0]); end
   endtask

   task automatic test_infer;
      mlp_out  = 2'b10;
      in_data  = 32'h12345678;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = 32'h0;
      total++; if (mlp_inp !== 32'h12345678 || busy !== 1'b1 || in_ready !== 1'b0) begin bad++;
         $display("FAIL infer_accept got inp=%h busy=%b in_ready=%b exp=12345678/1/0", mlp_inp, busy, in_ready); end
      for (int i = 1; i < 4; i++) begin
         tick();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL infer_early t+%0d got=%b exp=0", i, out_valid); end
      end
      tick();
      total++; if (out_valid !== 1'b1 || out_class !== 2'b10) begin bad++;
         $display("FAIL infer_capture got valid=%b class=%b exp=1/10", out_valid, out_class); end
      total++; if (mlp_inp !== 32'h12345678) begin bad++; $display("FAIL infer_inp_hold got=%h exp=12345678", mlp_inp); end
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin bad++;
         $display("FAIL infer_release got in_ready=%b valid=%b busy=%b exp=1/0/0", in_ready, out_valid, busy); end
   endtask

   task automatic test_hold_done;
      int errs = 0;
      mlp_out  = 2'b01;
      in_data  = 32'hCAFE0001;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < 10; i++) begin
         mlp_out = 2'(i);
         tick();
         if (out_valid !== 1'b1 || out_class !== 2'b01 || in_ready !== 1'b0) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL hold_done got %0d bad cycles exp=0 (class=%b)", errs, out_class); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release got=%b exp=1", in_ready); end
   endtask

   task automatic test_clear_vs_req;
      cfg_clear = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hDEADBEEF;
      tick();
      cfg_clear = 1'b0;
      total++; if ({cfg_ready, in_ready, param_loaded, busy} !== 4'b1000) begin bad++;
         $display("FAIL clear_state got=%b exp=1000", {cfg_ready, in_ready, param_loaded, busy}); end
      total++; if (mlp_inp !== 32'hCAFE0001 || mlp_weights !== exp_w) begin bad++;
         $display("FAIL clear_keep got inp=%h exp=cafe0001", mlp_inp); end
      tick();
      tick();
      total++; if (busy !== 1'b0 || mlp_inp !== 32'hCAFE0001) begin bad++;
         $display("FAIL empty_req got busy=%b inp=%h exp=0/cafe0001", busy, mlp_inp); end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midload;
      int acc = 0;
      int cnt;
      for (int c = 0; c < 400 && acc < 20; c++) begin
         cfg_valid = 1'($urandom_range(0, 1));
         cfg_data  = 8'($urandom_range(0, 255));
         if (cfg_valid && cfg_ready) acc++;
         tick();
      end
      cfg_valid = 1'b0;
      total++; if (acc != 20 || param_loaded !== 1'b0) begin bad++;
         $display("FAIL partial_load got acc=%0d loaded=%b exp=20/0", acc, param_loaded); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (cfg_ready !== 1'b1 || param_loaded !== 1'b0 || in_ready !== 1'b0) begin bad++;
         $display("FAIL midload_reset got cfg_ready=%b loaded=%b in_ready=%b exp=1/0/0", cfg_ready, param_loaded, in_ready); end
      total++; if (mlp_weights !== 264'h0 || mlp_biases !== 72'h0 || mlp_inp !== 32'h0 || out_class !== 2'b00) begin bad++;
         $display("FAIL midload_zero got w0=%h b0=%h inp=%h class=%b", mlp_weights[7:0], mlp_biases[7:0], mlp_inp, out_class); end
      #2;
      rst_n = 1'b1;
      tick();
      load_all(8'h5A, cnt);
      total++; if (cnt != 42 || param_loaded !== 1'b1 || param_loaded_1 !== 1'b1) begin bad++;
         $display("FAIL reload got cnt=%0d loaded=%b/%b exp=42/1/1", cnt, param_loaded, param_loaded_1); end
      total++; if (mlp_weights !== exp_w || mlp_biases !== exp_b) begin bad++;
         $display("FAIL reload_image got w=%h b=%h", mlp_weights, mlp_biases); end
   endtask

   task automatic test_clear_in_eval;
      mlp_out  = 2'b11;
      in_data  = 32'h0F0F0F0F;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      cfg_clear = 1'b1;
      tick();
      cfg_clear = 1'b0;
      total++; if (busy !== 1'b1 || param_loaded !== 1'b1) begin bad++;
         $display("FAIL eval_clear got busy=%b loaded=%b exp=1/1", busy, param_loaded); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL eval_clear_early got=%b exp=0", out_valid); end
      tick();
      total++; if (out_valid !== 1'b1 || out_class !== 2'b11) begin bad++;
         $display("FAIL eval_clear_capture got valid=%b class=%b exp=1/11", out_valid, out_class); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || param_loaded !== 1'b1) begin bad++;
         $display("FAIL eval_clear_idle got in_ready=%b loaded=%b exp=1/1", in_ready, param_loaded); end
   endtask

   task automatic test_back_to_back;
      int acc_cnt = 0;
      int acc_at[3];
      mlp_out_1  = 2'b11;
      in_data_1  = 32'hA5A5A5A5;
      in_valid_1 = 1'b1;
      tick();
      in_valid_1 = 1'b0;
      total++; if (busy_1 !== 1'b1 || out_valid_1 !== 1'b0) begin bad++;
         $display("FAIL s1_accept got busy=%b valid=%b exp=1/0", busy_1, out_valid_1); end
      tick();
      total++; if (out_valid_1 !== 1'b1 || out_class_1 !== 2'b11) begin bad++;
         $display("FAIL s1_capture got valid=%b class=%b exp=1/11", out_valid_1, out_class_1); end
      out_ready_1 = 1'b1;
      in_valid_1  = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_data_1 = 32'h100 + 32'(i);
         if (in_ready_1) begin
            if (acc_cnt < 3) acc_at[acc_cnt] = i;
            acc_cnt++;
         end
         tick();
      end
      in_valid_1  = 1'b0;
      out_ready_1 = 1'b0;
      total++; if (acc_cnt != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", acc_cnt); end
      else begin
         total++; if (acc_at[0] != 1 || acc_at[1] != 4 || acc_at[2] != 7) begin bad++;
            $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=1,4,7", acc_at[0], acc_at[1], acc_at[2]); end
      end
      total++; if (mlp_inp_1 !== 32'h107 || busy_1 !== 1'b1) begin bad++;
         $display("FAIL b2b_inp got inp=%h busy=%b exp=107/1", mlp_inp_1, busy_1); end
   endtask

   initial begin
      rst_n       = 1'b0;
      cfg_valid   = 1'b0;
      cfg_data    = 8'h0;
      cfg_clear   = 1'b0;
      cfg_clear_1 = 1'b0;
      in_valid    = 1'b0;
      in_valid_1  = 1'b0;
      in_data     = 32'h0;
      in_data_1   = 32'h0;
      out_ready   = 1'b0;
      out_ready_1 = 1'b0;
      mlp_out     = 2'b00;
      mlp_out_1   = 2'b00;
      exp_w       = '0;
      exp_b       = '0;

      test_reset();
      test_load();
      test_cfg_ignored();
      test_infer();
      test_hold_done();
      test_clear_vs_req();
      test_reset_midload();
      test_clear_in_eval();
      test_back_to_back();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
